addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, multi-cycle two's-complement add/subtract unit for the ALU datapath. It builds on the single-bit full-adder cell and processes operands LSB-first, DIGIT bits per clock, over WIDTH/DIGIT cycles. It uses a start/busy/done handshake, and its registered result holds carry, signed-overflow and zero flags. It sits between the operand registers and the ALU result mux, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT.
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  final carry out; for subtract 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Latch a; latch b XOR {WIDTH{op}}; carry register ← op.
  - Digit counter ← 0; go to RUN.
- **IDLE, start=0:** stay in IDLE.
- **RUN, each edge:**
  - Combine the lowest DIGIT bits of a and b with the carry register.
  - Shift the DIGIT-bit sum into the top of the internal accumulator (LSB-first, so it ends aligned).
  - Shift a and b right by DIGIT; update the carry register; increment the counter.
- **RUN, edge with counter == N−1:**
  - Load result, cout, ovf and zero from the completed accumulator and carries.
  - Go to DONE.
- **DONE:** done = 1 for exactly one cycle; next edge → IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queueing, and a start in DONE is dropped.
- result, cout, ovf and zero change only on the RUN→DONE edge. They hold until the next operation completes.
- ovf uses the carry into bit WIDTH−1, captured during the final digit.
- zero is evaluated on the full WIDTH-bit final sum.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - The carry chain is DIGIT+1 bits per cycle.
  - The counter is $clog2(N) bits, with a minimum of 1.

## Timing
- Reset (rst=1 at an edge):
  - State → IDLE.
  - busy, done, result, cout, ovf and zero all → 0.
  - The accumulator, counter and carry are cleared.
- Reset during RUN or DONE aborts the operation: no done pulse and no result update.
- Reset has priority over start on the same edge.
- Latency: with start sampled at edge k, busy is high after edges k+1 … k+N. done is high during the cycle after edge k+N+1.
  - Result is valid N+1 edges after the start edge.
  - DIGIT=WIDTH gives N=1, so done follows 2 edges after start.
- Throughput: one operation per N+2 cycles (the IDLE cycle is required before the next start).
- busy and done are never high together.

## Structure
- Shared package addsub_pkg:
  - State enum (IDLE, RUN, DONE).
  - Op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module addsub_slice (parameter DIGIT), a DIGIT-bit ripple of full-adder cells.
  - Inputs: a_d, b_d, cin.
  - Outputs: sum_d, cout, c_top (carry into its top bit, used for ovf).
- Top level: FSM, counter, operand shift registers, accumulator and output registers.

## Test plan
- WIDTH=8, DIGIT=1; add 0x7F + 0x01 → result 0x80, cout 0, ovf 1, zero 0; done exactly 9 edges after the start edge; busy high for 8 cycles.
- Subtract 0x05 − 0x05 → 0x00, cout 1, ovf 0, zero 1. Subtract 0x03 − 0x05 → 0xFE, cout 0, ovf 0.
- Add 0xFF + 0x01 → 0x00, cout 1, ovf 0, zero 1. Subtract 0x80 − 0x01 → 0x7F, cout 1, ovf 1.
- WIDTH=8, DIGIT=4: add 0x3C + 0x4D → 0x89, ovf 1; done 3 edges after start. Repeat with WIDTH=16, DIGIT=16: add 0x1234 + 0x0FFF → 0x2233 after 2 edges.
- Pulse start with new operands mid-RUN and again in DONE → both ignored; result reflects the first operands only; result holds through following IDLE cycles.
- Assert rst at RUN cycle 4 → no done pulse; all outputs 0 next cycle; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit.
// Latency: n/a (types, constants and the full-adder cell only).
// Backpressure: n/a.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Single-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// DIGIT-bit ripple of full-adder cells; also exposes the carry into its top bit.
// Latency: combinational.
// Backpressure: none.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_d,
    output logic             cout,
    output logic             c_top
);

    logic [DIGIT:0] c;

    always_comb begin
        c     = '0;
        sum_d = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            {c[i+1], sum_d[i]} = fa(a_d[i], b_d[i], c[i]);
        end
    end

    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/subtract, LSB first, DIGIT bits per clock.
// Latency: done is high in the cycle after edge k+N+1 for a start sampled at edge k.
// Backpressure: none; start is only accepted in IDLE and is dropped otherwise.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_serial: WIDTH must be at least 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
        $error("addsub_serial: DIGIT must divide WIDTH");
    end

    state_t                 state;
    logic [WIDTH-1:0]       a_sr;
    logic [WIDTH-1:0]       b_sr;
    logic [WIDTH-1:0]       acc;
    logic                   carry;
    logic [CW-1:0]          cnt;

    logic [DIGIT-1:0]       sum_d;
    logic                   c_out;
    logic                   c_top;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_nxt;

    addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d   (a_sr[DIGIT-1:0]),
        .b_d   (b_sr[DIGIT-1:0]),
        .cin   (carry),
        .sum_d (sum_d),
        .cout  (c_out),
        .c_top (c_top)
    );

    // New digit enters at the top so the final digit lands the sum LSB-aligned.
    assign acc_cat = {sum_d, acc};
    assign acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        // Subtract as a + ~b + 1: invert b and seed the carry.
                        b_sr  <= b ^ {WIDTH{op}};
                        carry <= op;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        result <= acc_nxt;
                        cout   <= c_out;
                        ovf    <= c_out ^ c_top;
                        zero   <= (acc_nxt == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed-vector bench for addsub_serial at three WIDTH/DIGIT configurations.
// Expected values are hand-computed constants.
module tb_addsub_serial;

    import addsub_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic       s0, o0, busy0, done0, cout0, ovf0, zero0;
    logic [7:0] a0, b0, res0;
    logic       s1, o1, busy1, done1, cout1, ovf1, zero1;
    logic [7:0] a1, b1, res1;
    logic        s2, o2, busy2, done2, cout2, ovf2, zero2;
    logic [15:0] a2, b2, res2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(s0), .op(o0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(res0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .op(o1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2), .op(o2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic o,
                         input logic [15:0] x, input logic [15:0] y);
        case (sel)
            0:       begin s0 = s; o0 = o; a0 = x[7:0]; b0 = y[7:0]; end
            1:       begin s1 = s; o1 = o; a1 = x[7:0]; b1 = y[7:0]; end
            default: begin s2 = s; o2 = o; a2 = x;      b2 = y;      end
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // {zero, ovf, cout, result}
    function automatic logic [18:0] get_out(input int sel);
        case (sel)
            0:       return {zero0, ovf0, cout0, 8'h00, res0};
            1:       return {zero1, ovf1, cout1, 8'h00, res1};
            default: return {zero2, ovf2, cout2, res2};
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done; called and returns at a negedge.
    task automatic run_op(input string tag, input int sel, input logic o,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] e_res, input logic e_c, input logic e_v,
                          input logic e_z, input int e_edges, input int e_busy);
        int edges;
        int busyc;
        int both;
        logic [18:0] out;
        edges = 0;
        busyc = 0;
        both  = 0;
        @(negedge clk);
        drive(sel, 1'b1, o, x, y);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            edges++;
            if (get_busy(sel)) busyc++;
            if (get_busy(sel) && get_done(sel)) both++;
            if (get_done(sel)) break;
        end
        out = get_out(sel);
        check({tag, "_edges"}, edges, e_edges);
        check({tag, "_busy"}, busyc, e_busy);
        check({tag, "_overlap"}, both, 0);
        check({tag, "_res"}, out[15:0], e_res);
        check({tag, "_cout"}, out[16], e_c);
        check({tag, "_ovf"}, out[17], e_v);
        check({tag, "_zero"}, out[18], e_z);
        @(negedge clk);
        check({tag, "_pulse"}, get_done(sel), 1'b0);
    endtask

    initial begin
        int donecnt;
        int first_done;
        int busyc;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(2, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_out0", get_out(0), 19'h0);
        check("rst_out2", get_out(2), 19'h0);
        rst = 1'b0;

        run_op("add_7f_01", 0, OP_ADD, 16'h7F, 16'h01, 16'h80, 1'b0, 1'b1, 1'b0, 9, 8);
        run_op("sub_05_05", 0, OP_SUB, 16'h05, 16'h05, 16'h00, 1'b1, 1'b0, 1'b1, 9, 8);
        run_op("sub_03_05", 0, OP_SUB, 16'h03, 16'h05, 16'hFE, 1'b0, 1'b0, 1'b0, 9, 8);
        run_op("add_ff_01", 0, OP_ADD, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0, 1'b1, 9, 8);
        run_op("sub_80_01", 0, OP_SUB, 16'h80, 16'h01, 16'h7F, 1'b1, 1'b1, 1'b0, 9, 8);
        run_op("d4_add", 1, OP_ADD, 16'h3C, 16'h4D, 16'h89, 1'b0, 1'b1, 1'b0, 3, 2);
        run_op("d16_add", 2, OP_ADD, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 2, 1);

        // Starts mid-RUN (cycle 3) and while in DONE (cycle 8) must be dropped.
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 16'h10, 16'h20);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        donecnt    = 0;
        first_done = 0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (done0) begin
                donecnt++;
                if (first_done == 0) first_done = e;
            end
            if (e == 3 || e == 8) drive(0, 1'b1, OP_SUB, 16'hFF, 16'h77);
            else drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        check("ign_first_done", first_done, 9);
        check("ign_done_count", donecnt, 1);
        check("ign_res_hold", res0, 8'h30);
        check("ign_idle", busy0, 1'b0);

        // Reset in RUN aborts the operation.
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 16'h11, 16'h22);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_out", get_out(0), 19'h0);
        donecnt = 0;
        busyc   = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (done0) donecnt++;
            if (busy0) busyc++;
        end
        check("abort_no_done", donecnt, 0);
        check("abort_no_busy", busyc, 0);
        run_op("after_rst", 0, OP_ADD, 16'h11, 16'h22, 16'h33, 1'b0, 1'b0, 1'b0, 9, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
